// File: rtl/bsg_subtractor_serial.sv
// bsg_subtractor_serial: multi-cycle unsigned subtractor, d = a - b.
// One chunk_p-bit slice per cycle, LSB slice first, with a registered
// borrow (held as carry of a + ~b + 1) between slices. Producer side is
// ready/valid, consumer side is valid/yumi.
// Optional feature macro: BSG_SUBTRACTOR_SERIAL_OVF_EN adds ovf_o, the
// two's-complement signed overflow flag of the subtraction.

module bsg_subtractor_serial #(
  parameter int width_p = 16,
  parameter int chunk_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] d_o,
  output logic               borrow_o,
  input  logic               yumi_i
`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
  , output logic             ovf_o
`endif
);

  localparam int els_lp   = width_p / chunk_p;
  localparam int cnt_w_lp = (els_lp > 1) ? $clog2(els_lp) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [width_p-1:0]   a_q, a_d;
  logic [width_p-1:0]   b_q, b_d;
  logic [width_p-1:0]   res_q, res_d;
  logic                 carry_q, carry_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 v_q, v_d;

  logic [chunk_p-1:0]   sum;
  logic                 cout;
  logic [width_p-1:0]   a_sh, b_sh, res_sh;

  // Slice adder: low chunk of A, low chunk of inverted B, plus carry
  assign {cout, sum} = {1'b0, a_q[chunk_p-1:0]}
                     + {1'b0, b_q[chunk_p-1:0]}
                     + (chunk_p+1)'(carry_q);

  // Shifted views; the single-slice build has nothing left to shift in
  if (chunk_p == width_p) begin : g_one
    assign a_sh   = '0;
    assign b_sh   = '0;
    assign res_sh = sum;
  end else begin : g_multi
    assign a_sh   = {{chunk_p{1'b0}}, a_q[width_p-1:chunk_p]};
    assign b_sh   = {{chunk_p{1'b0}}, b_q[width_p-1:chunk_p]};
    assign res_sh = {sum, res_q[width_p-1:chunk_p]};
  end

`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
  // Original operand signs; B is stored inverted so its sign is kept here
  logic sa_q, sa_d, sb_q, sb_d;
`endif

  // Next-state logic for the IDLE -> BUSY -> DONE sequence
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    v_d     = v_q;
`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
    sa_d    = sa_q;
    sb_d    = sb_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // ready_q is 0 only in the first cycle after reset
        ready_d = 1'b1;
        if (v_i & ready_q) begin
          a_d     = a_i;
          b_d     = ~b_i;
          carry_d = 1'b1;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = S_BUSY;
`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
          sa_d    = a_i[width_p-1];
          sb_d    = b_i[width_p-1];
`endif
        end
      end
      S_BUSY: begin
        a_d     = a_sh;
        b_d     = b_sh;
        res_d   = res_sh;
        carry_d = cout;
        cnt_d   = cnt_q + cnt_w_lp'(1);
        if (cnt_q == cnt_w_lp'(els_lp - 1)) begin
          v_d     = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Result held until the consumer takes it
        if (yumi_i) begin
          v_d     = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        v_d     = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b1;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      v_q     <= 1'b0;
`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      v_q     <= v_d;
`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
      sa_q    <= sa_d;
      sb_q    <= sb_d;
`endif
    end
  end

  assign ready_o  = ready_q;
  assign v_o      = v_q;
  assign d_o      = res_q;
  // Final carry of a + ~b + 1 is 0 exactly when a < b
  assign borrow_o = ~carry_q;

`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
  // Signs differ and the result sign departs from the minuend sign
  assign ovf_o = v_q & (sa_q ^ sb_q) & (res_q[width_p-1] ^ sa_q);
`endif

endmodule

// File: tb/tb_bsg_subtractor_serial.sv
// Bench for bsg_subtractor_serial: default 16/4 instance plus a 16/16
// single-slice instance, each with an expected-result queue popped on
// every v_o & yumi_i handshake.

module tb_bsg_subtractor_serial;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] d;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         v_i = 1'b0, yumi_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         ready_o, v_o, borrow_o;
  logic [W-1:0] d_o;
  logic         v1_i = 1'b0, yumi1_i = 1'b0;
  logic [W-1:0] a1_i = '0, b1_i = '0;
  logic         ready1_o, v1_o, borrow1_o;
  logic [W-1:0] d1_o;
`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
  logic         ovf_o, ovf1_o;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;

  bsg_subtractor_serial #(.width_p(W), .chunk_p(4)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .a_i(a_i), .b_i(b_i),
    .ready_o(ready_o), .v_o(v_o), .d_o(d_o), .borrow_o(borrow_o),
    .yumi_i(yumi_i)
`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
    , .ovf_o(ovf_o)
`endif
  );

  bsg_subtractor_serial #(.width_p(W), .chunk_p(W)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v1_i), .a_i(a1_i), .b_i(b1_i),
    .ready_o(ready1_o), .v_o(v1_o), .d_o(d1_o), .borrow_o(borrow1_o),
    .yumi_i(yumi1_i)
`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
    , .ovf_o(ovf1_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.d      = a - b;
    e.borrow = (a < b);
    e.ovf    = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic rdy(input bit s);
    return s ? ready1_o : ready_o;
  endfunction

  function automatic logic vo(input bit s);
    return s ? v1_o : v_o;
  endfunction

  task automatic drive(input bit s, input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic y);
    if (s) begin v1_i = v; a1_i = a; b1_i = b; yumi1_i = y; end
    else   begin v_i  = v; a_i  = a; b_i  = b; yumi_i  = y; end
  endtask

  // Scoreboard pop for the default instance
  always @(negedge clk) begin
    #2;
    if (rst_n && v_o && yumi_i) begin
      if (q0.size() == 0) chk("spurious_vo", 32'(v_o), 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("d", 32'(d_o), 32'(e0.d));
        chk("borrow", 32'(borrow_o), 32'(e0.borrow));
`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
        chk("ovf", 32'(ovf_o), 32'(e0.ovf));
`endif
      end
    end
  end

  // Scoreboard pop for the single-slice instance
  always @(negedge clk) begin
    #2;
    if (rst_n && v1_o && yumi1_i) begin
      if (q1.size() == 0) chk("spurious_vo1", 32'(v1_o), 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("d1", 32'(d1_o), 32'(e1.d));
        chk("borrow1", 32'(borrow1_o), 32'(e1.borrow));
`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
        chk("ovf1", 32'(ovf1_o), 32'(e1.ovf));
`endif
      end
    end
  end

  // One operation with yumi held high; starts and ends at a negedge
  task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat);
    int n;
    n = 0;
    while (!rdy(s) && n < 20) begin step(); n++; end
    chk("ready_before", 32'(rdy(s)), 32'd1);
    #1;
    drive(s, 1'b1, a, b, 1'b1);
    if (s) q1.push_back(model(a, b)); else q0.push_back(model(a, b));
    step();
    #1;
    drive(s, 1'b0, a, b, 1'b1);
    n = 0;
    while (!vo(s) && n < 20) begin step(); n++; end
    chk("latency", 32'(n), 32'(exp_lat));
    step();
    chk("ready_after", 32'(rdy(s)), 32'd1);
    chk("v_after", 32'(vo(s)), 32'd0);
  endtask

  initial begin
    exp_t eb;
    int   n;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_v", 32'(v_o), 32'd0);
    chk("rst_d", 32'(d_o), 32'd0);
    chk("rst_borrow", 32'(borrow_o), 32'd0);
    chk("rst_ready1", 32'(ready1_o), 32'd0);
    chk("rst_v1", 32'(v1_o), 32'd0);
`ifdef BSG_SUBTRACTOR_SERIAL_OVF_EN
    chk("rst_ovf", 32'(ovf_o), 32'd0);
`endif
    step();
    #1 rst_n = 1'b1;
    step();
    chk("ready_post_rst", 32'(ready_o), 32'd1);
    chk("ready1_post_rst", 32'(ready1_o), 32'd1);

    run_op(1'b0, 16'h1234, 16'h0234, 4);
    run_op(1'b0, 16'h0000, 16'h0001, 4);
    run_op(1'b0, 16'h8000, 16'h0001, 4);
    run_op(1'b0, 16'h7FFF, 16'hFFFF, 4);

    // Backpressure: result held 10 cycles, a v_i pulse in DONE is dropped
    eb = model(16'h0F00, 16'h1000);
    #1;
    drive(1'b0, 1'b1, 16'h0F00, 16'h1000, 1'b0);
    q0.push_back(eb);
    step();
    #1 v_i = 1'b0;
    n = 0;
    while (!v_o && n < 20) begin step(); n++; end
    chk("bp_latency", 32'(n), 32'd4);
    for (int k = 0; k < 10; k++) begin
      chk("bp_v", 32'(v_o), 32'd1);
      chk("bp_d", 32'(d_o), 32'(eb.d));
      chk("bp_borrow", 32'(borrow_o), 32'(eb.borrow));
      chk("bp_ready", 32'(ready_o), 32'd0);
      if (k == 3) begin #1 drive(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0); end
      if (k == 4) begin #1 v_i = 1'b0; end
      step();
    end
    #1 yumi_i = 1'b1;
    step();
    chk("bp_v_after", 32'(v_o), 32'd0);
    chk("bp_ready_after", 32'(ready_o), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("bp_no_second", 32'(v_o), 32'd0);
    end

    for (int k = 0; k < 4; k++)
      run_op(1'b0, W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), 4);

    // Reset after two BUSY cycles aborts the operation
    #1;
    drive(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1);
    q0.push_back(model(16'h1111, 16'h2222));
    step();
    #1 v_i = 1'b0;
    step();
    step();
    #1 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("mid_rst_v", 32'(v_o), 32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd0);
    step();
    chk("mid_rst_v_hold", 32'(v_o), 32'd0);
    chk("mid_rst_ready_hold", 32'(ready_o), 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk("mid_rst_ready_rel", 32'(ready_o), 32'd1);
    chk("mid_rst_no_v", 32'(v_o), 32'd0);
    run_op(1'b0, 16'h00FF, 16'h0F0F, 4);

    // Single-slice build
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 1);
    run_op(1'b1, 16'h0001, 16'h0002, 1);
    run_op(1'b1, 16'h8000, 16'h0001, 1);
    for (int k = 0; k < 3; k++)
      run_op(1'b1, W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), 1);

    step();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
